ram_rr_arbiter: RTL

//  Two-port round-robin arbiter/sequencer for the word-organised JK-flip-flop RAM array.

---
 rtl/ram_rr_arbiter_pkg.sv | 15 +
 rtl/ram_rr_arbiter_rr_pick2.sv | 16 +
 rtl/ram_rr_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ram_rr_arbiter_pkg.sv
// Shared definitions for the two-port RAM round-robin arbiter: FSM state
// encodings and default widths.
package ram_rr_arbiter_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_VERIFY = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ram_rr_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins, a contest
// goes to the side that was not served last.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic win,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    win   = (req0 & req1) ? ~last : req1;
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Two-port round-robin arbiter/sequencer for the word-organised RAM array.
// Optional write-verify pass enabled by defining RAM_ARB_VERIFY_EN.
module ram_rr_arbiter
  import ram_rr_arbiter_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int ADDR_W = ADDR_W_DEF,
  localparam int WORDS  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [WORDS-1:0]  ram_sel,
  output logic              ram_rw,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  arb_state_t        state;
  logic              last;
  logic              cur;
  logic              cur_we;
  logic              pick_win;
  logic              pick_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    sel_we    = pick_win ? we1    : we0;
    sel_addr  = pick_win ? addr1  : addr0;
    sel_wdata = pick_win ? wdata1 : wdata0;
  end

`ifdef RAM_ARB_VERIFY_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // ram_sel/ram_din are registered at the grant edge so they are stable a full
  // cycle before the write edge; ram_din doubles as the latched write data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      last    <= 1'b1;
      cur     <= 1'b0;
      cur_we  <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      ram_sel <= '0;
      ram_din <= '0;
      rdata   <= '0;
`ifdef RAM_ARB_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            cur     <= pick_win;
            cur_we  <= sel_we;
            gnt0    <= ~pick_win;
            gnt1    <= pick_win;
            ram_sel <= {{(WORDS-1){1'b0}}, 1'b1} << sel_addr;
            ram_din <= sel_wdata;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!cur_we) rdata <= ram_dout;
`ifdef RAM_ARB_VERIFY_EN
          if (cur_we) begin
            state <= ST_VERIFY;
          end else begin
            state <= ST_RESP;
            ack0  <= ~cur;
            ack1  <= cur;
          end
`else
          state <= ST_RESP;
          ack0  <= ~cur;
          ack1  <= cur;
`endif
        end
`ifdef RAM_ARB_VERIFY_EN
        ST_VERIFY: begin
          if (ram_dout != ram_din) err_q <= 1'b1;
          state <= ST_RESP;
          ack0  <= ~cur;
          ack1  <= cur;
        end
`endif
        ST_RESP: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          ram_sel <= '0;
          last    <= cur;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write strobe rises mid-ACCESS and falls mid-following-state, so the
  // array's clk&rw gate opens only around the posedge that ends ACCESS.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) ram_rw <= 1'b0;
    else       ram_rw <= (state == ST_ACCESS) && cur_we;
  end

endmodule
